// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory port arbiter.
// Address range and alignment helpers live here so every user agrees.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RWAIT
  } state_t;

  localparam int MEM_AW     = 7;
  localparam int WORD_BYTES = 4;
  localparam int STRK_W     = 4;

  localparam logic [31:0] ADDR_LIMIT =
    32'(WORD_BYTES * (1 << MEM_AW));

  function automatic logic addr_bad(
    input logic [31:0] a
  );
    return (a[1:0] != 2'b00) || (a >= ADDR_LIMIT);
  endfunction

endpackage

// File: rtl/mips_mem_arb_pick.sv
// Winner select between fetch and load/store, with the
// starvation streak update applied at arbitration points.
module mips_mem_arb_pick
  import mips_mem_pkg::*;
#(
  parameter int MAX_LS_STREAK = 4
) (
  input  logic              i_if_req,
  input  logic              i_ls_req,
  input  logic [STRK_W-1:0] i_streak,
  output logic              o_pick_if,
  output logic              o_pick_ls,
  output logic [STRK_W-1:0] o_streak
);

  logic w_starve;

  assign w_starve =
    i_if_req && (i_streak == STRK_W'(MAX_LS_STREAK));

  always_comb begin
    o_pick_ls = i_ls_req && !w_starve;
    o_pick_if = i_if_req && !o_pick_ls;
    o_streak  = i_streak;
    unique case (1'b1)
      o_pick_if: o_streak = '0;
      o_pick_ls: o_streak = i_if_req ? i_streak + 1'b1 : '0;
      default:   o_streak = i_streak;
    endcase
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one SRAM port between instruction fetch and load/store,
// with configurable read latency and a fetch starvation guard.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int READ_LAT      = 1,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              err,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [MEM_AW-1:0] A,
  output logic [31:0]       Data2Mem,
  input  logic [31:0]       ReadDataMem
);

  localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

  state_t            r_state;
  state_t            w_state_n;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_n;
  logic [STRK_W-1:0] r_streak;
  logic [STRK_W-1:0] w_streak_n;

  logic              r_we;
  logic              r_bad;
  logic              r_is_if;
  logic [MEM_AW-1:0] r_a;
  logic [31:0]       r_wdata;
  logic              r_if_gnt;
  logic              r_ls_gnt;
  logic              r_err;
  logic              r_if_rvalid;
  logic              r_ls_rvalid;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_ls_rdata;

  logic              w_pick_if;
  logic              w_pick_ls;
  logic              w_last;
  logic              w_arb;
  logic              w_go;
  logic              w_launch_ok;
  logic [31:0]       w_addr;

  mips_mem_arb_pick #(
    .MAX_LS_STREAK(MAX_LS_STREAK)
  ) u_pick (
    .i_if_req (if_req),
    .i_ls_req (ls_req),
    .i_streak (r_streak),
    .o_pick_if(w_pick_if),
    .o_pick_ls(w_pick_ls),
    .o_streak (w_streak_n)
  );

  // Errored launches finish like writes, so they re-arbitrate too.
  assign w_last = (r_state == RWAIT) && (r_cnt == 2'd0);
  assign w_arb  = (r_state == IDLE)
               || ((r_state == LAUNCH) && (r_we || r_bad))
               || w_last;
  assign w_go   = w_arb && (w_pick_if || w_pick_ls);
  assign w_addr = w_pick_ls ? ls_addr : if_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (w_arb) begin
      w_state_n = w_go ? LAUNCH : IDLE;
    end else begin
      unique case (r_state)
        LAUNCH: begin
          w_state_n = RWAIT;
          w_cnt_n   = CNT_INIT;
        end
        RWAIT:   w_cnt_n = r_cnt - 2'd1;
        default: w_cnt_n = r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak    <= '0;
      r_we        <= 1'b0;
      r_bad       <= 1'b0;
      r_is_if     <= 1'b0;
      r_a         <= '0;
      r_wdata     <= '0;
      r_if_gnt    <= 1'b0;
      r_ls_gnt    <= 1'b0;
      r_err       <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_gnt    <= 1'b0;
      r_ls_gnt    <= 1'b0;
      r_err       <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      if (w_arb) begin
        r_streak <= w_streak_n;
      end
      if (w_go) begin
        r_if_gnt <= w_pick_if;
        r_ls_gnt <= w_pick_ls;
        r_err    <= addr_bad(w_addr);
        r_bad    <= addr_bad(w_addr);
        r_we     <= w_pick_ls && ls_we;
        r_is_if  <= w_pick_if;
        r_a      <= w_addr[MEM_AW+1:2];
        if (w_pick_ls) begin
          r_wdata <= ls_wdata;
        end
      end
      // r_is_if still names the finishing read here.
      if (w_last) begin
        if (r_is_if) begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= ReadDataMem;
        end else begin
          r_ls_rvalid <= 1'b1;
          r_ls_rdata  <= ReadDataMem;
        end
      end
    end
  end

  assign w_launch_ok = (r_state == LAUNCH) && !r_bad;

  assign CEN      = !w_launch_ok;
  assign WEN      = !(w_launch_ok && r_we);
  assign OEN      = !((w_launch_ok && !r_we)
                   || (r_state == RWAIT));
  assign A        = r_a;
  assign Data2Mem = r_wdata;

  assign if_gnt    = r_if_gnt;
  assign ls_gnt    = r_ls_gnt;
  assign err       = r_err;
  assign if_rvalid = r_if_rvalid;
  assign ls_rvalid = r_ls_rvalid;
  assign if_rdata  = r_if_rdata;
  assign ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench: vector table for single LS accesses, plus
// sequences for back-to-back, starvation and mid-read reset.
module tb_mips_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // ---------------- DUT with READ_LAT=1 ----------------
  logic        rst;
  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, err;
  logic [31:0] if_rdata, ls_rdata;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] Data2Mem, ReadDataMem;

  mips_mem_arbiter #(.READ_LAT(1), .MAX_LS_STREAK(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .err(err),
    .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A),
    .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem)
  );

  logic [31:0] mem [128];
  logic [6:0]  la;
  always @(posedge clk) begin
    if (!CEN && !WEN) mem[A] <= Data2Mem;
    if (!CEN && WEN) la <= A;
  end
  assign ReadDataMem = mem[la];

  // ---------------- DUT with READ_LAT=3 ----------------
  logic        rst3;
  logic        if3_req, ls3_req, ls3_we;
  logic [31:0] if3_addr, ls3_addr, ls3_wdata;
  logic        if3_gnt, if3_rvalid, ls3_gnt, ls3_rvalid, err3;
  logic [31:0] if3_rdata, ls3_rdata;
  logic        CEN3, WEN3, OEN3;
  logic [6:0]  A3;
  logic [31:0] D2M3, RDM3;

  mips_mem_arbiter #(.READ_LAT(3), .MAX_LS_STREAK(4)) u_dut3 (
    .clk(clk), .rst(rst3),
    .if_req(if3_req), .if_addr(if3_addr),
    .if_gnt(if3_gnt), .if_rvalid(if3_rvalid),
    .if_rdata(if3_rdata),
    .ls_req(ls3_req), .ls_we(ls3_we),
    .ls_addr(ls3_addr), .ls_wdata(ls3_wdata),
    .ls_gnt(ls3_gnt), .ls_rvalid(ls3_rvalid),
    .ls_rdata(ls3_rdata), .err(err3),
    .CEN(CEN3), .WEN(WEN3), .OEN(OEN3), .A(A3),
    .Data2Mem(D2M3), .ReadDataMem(RDM3)
  );

  logic [31:0] mem3 [128];
  logic [6:0]  la3;
  always @(posedge clk) begin
    if (!CEN3 && !WEN3) mem3[A3] <= D2M3;
    if (!CEN3 && WEN3) la3 <= A3;
  end
  assign RDM3 = mem3[la3];

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [6:0]  a;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [10];

  task automatic run_ls(input int i, input vec_t v);
    int n;
    ls_req = 1'b1; ls_we = v.we;
    ls_addr = v.addr; ls_wdata = v.wdata;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!ls_gnt && n < 8);
    ls_req = 1'b0;
    chk($sformatf("v%0d_gnt_lat", i), n, 1);
    chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, v.err});
    if (v.err) begin
      chk($sformatf("v%0d_cen", i), {31'd0, CEN}, 1);
      repeat (3) begin
        @(negedge clk);
        chk($sformatf("v%0d_no_rvalid", i), {31'd0, ls_rvalid}, 0);
        chk($sformatf("v%0d_cen_hi", i), {31'd0, CEN}, 1);
      end
    end else begin
      chk($sformatf("v%0d_cen", i), {31'd0, CEN}, 0);
      chk($sformatf("v%0d_wen", i), {31'd0, WEN}, {31'd0, !v.we});
      chk($sformatf("v%0d_a", i), {25'd0, A}, {25'd0, v.a});
      if (!v.we) begin
        n = 0;
        do begin @(negedge clk); n++; end
        while (!ls_rvalid && n < 8);
        chk($sformatf("v%0d_rv_lat", i), n, 2);
        chk($sformatf("v%0d_rdata", i), ls_rdata, v.rdata);
      end else begin
        @(negedge clk);
      end
    end
  endtask

  string exp_ord;
  string got;

  initial begin
    int n;
    for (int k = 0; k < 128; k++) begin
      mem[k] = 32'h0; mem3[k] = 32'h0;
    end
    mem[0]  = 32'hA5A50000;
    mem[4]  = 32'hDEADBEEF;
    mem[8]  = 32'h11112222;
    mem3[4] = 32'hDEADBEEF;
    mem3[5] = 32'h0BADF00D;

    vt[0] = '{1'b0, 32'h10,       32'h0,        1'b0, 7'd4,   32'hDEADBEEF};
    vt[1] = '{1'b1, 32'h1FC,      32'h12345678, 1'b0, 7'd127, 32'h0};
    vt[2] = '{1'b0, 32'h1FC,      32'h0,        1'b0, 7'd127, 32'h12345678};
    vt[3] = '{1'b1, 32'h202,      32'hFFFFFFFF, 1'b1, 7'd0,   32'h0};
    vt[4] = '{1'b0, 32'h0,        32'h0,        1'b0, 7'd0,   32'hA5A50000};
    vt[5] = '{1'b0, 32'h1FD,      32'h0,        1'b1, 7'd0,   32'h0};
    vt[6] = '{1'b1, 32'h8,        32'hCAFEF00D, 1'b0, 7'd2,   32'h0};
    vt[7] = '{1'b0, 32'h8,        32'h0,        1'b0, 7'd2,   32'hCAFEF00D};
    vt[8] = '{1'b0, 32'h200,      32'h0,        1'b1, 7'd0,   32'h0};
    vt[9] = '{1'b0, 32'h80000010, 32'h0,        1'b1, 7'd0,   32'h0};

    if_req = 0; ls_req = 0; ls_we = 0;
    if_addr = 0; ls_addr = 0; ls_wdata = 0;
    if3_req = 0; ls3_req = 0; ls3_we = 0;
    if3_addr = 0; ls3_addr = 0; ls3_wdata = 0;
    rst = 1'b1; rst3 = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_cen", {31'd0, CEN}, 1);
    chk("rst_wen", {31'd0, WEN}, 1);
    chk("rst_oen", {31'd0, OEN}, 1);
    chk("rst_a", {25'd0, A}, 0);
    chk("rst_d2m", Data2Mem, 0);
    chk("rst_gnt", {30'd0, if_gnt, ls_gnt}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_rdata", ls_rdata | if_rdata, 0);
    rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_ls(i, vt[i]);

    // store then load held back-to-back to the same word
    ls_req = 1; ls_we = 1; ls_addr = 32'h40; ls_wdata = 32'h55AA55AA;
    n = 0;
    do begin @(negedge clk); n++; end while (!ls_gnt && n < 8);
    chk("b2b_st_lat", n, 1);
    chk("b2b_st_wen", {31'd0, WEN}, 0);
    chk("b2b_st_a", {25'd0, A}, 16);
    ls_we = 0;
    @(negedge clk);
    chk("b2b_ld_gnt", {31'd0, ls_gnt}, 1);
    chk("b2b_ld_cen", {30'd0, CEN, WEN}, 1);
    chk("b2b_ld_a", {25'd0, A}, 16);
    ls_req = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!ls_rvalid && n < 8);
    chk("b2b_rv_lat", n, 2);
    chk("b2b_rdata", ls_rdata, 32'h55AA55AA);

    // fetch ignores ls_we
    if_req = 1; if_addr = 32'h20; ls_we = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_gnt && n < 8);
    if_req = 0;
    chk("if_lat", n, 1);
    chk("if_strobes", {28'd0, CEN, WEN, OEN, ls_gnt}, 32'b0100);
    chk("if_a", {25'd0, A}, 8);
    n = 0;
    do begin @(negedge clk); n++; end while (!if_rvalid && n < 8);
    ls_we = 0;
    chk("if_rv_lat", n, 2);
    chk("if_rdata", if_rdata, 32'h11112222);

    // starvation guard with both requesters held
    exp_ord = "LLLLILLLLI";
    got = "";
    if_req = 1; if_addr = 32'h20;
    ls_req = 1; ls_addr = 32'h10;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      do begin @(negedge clk); n++; end
      while (!if_gnt && !ls_gnt && n < 20);
      chk($sformatf("strk_one_gnt%0d", g), {31'd0, if_gnt & ls_gnt}, 0);
      if (ls_gnt) got = {got, "L"};
      else if (if_gnt) got = {got, "I"};
      else got = {got, "-"};
    end
    if_req = 0; ls_req = 0;
    n_chk++;
    if (got != exp_ord) begin
      n_err++;
      $display("FAIL strk_order act=%s exp=%s", got, exp_ord);
    end
    repeat (4) @(negedge clk);

    // READ_LAT=3: one full fetch, then reset mid-read
    if3_req = 1; if3_addr = 32'h14;
    n = 0;
    do begin @(negedge clk); n++; end while (!if3_gnt && n < 8);
    if3_req = 0;
    chk("l3_gnt_lat", n, 1);
    chk("l3_cen", {31'd0, CEN3}, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!if3_rvalid && n < 12);
    chk("l3_rv_lat", n, 4);
    chk("l3_rdata", if3_rdata, 32'h0BADF00D);

    if3_req = 1; if3_addr = 32'h10;
    n = 0;
    do begin @(negedge clk); n++; end while (!if3_gnt && n < 8);
    if3_req = 0;
    chk("l3b_gnt_lat", n, 1);
    @(negedge clk);
    chk("l3b_rwait1", {30'd0, CEN3, OEN3}, 32'b10);
    @(posedge clk);
    #2 rst3 = 1'b1;
    #1;
    chk("l3r_strobes", {29'd0, CEN3, WEN3, OEN3}, 32'b111);
    chk("l3r_a", {25'd0, A3}, 0);
    chk("l3r_d2m", D2M3, 0);
    chk("l3r_flags", {28'd0, if3_gnt, ls3_gnt, if3_rvalid, err3}, 0);
    chk("l3r_rdata", if3_rdata, 0);
    @(negedge clk);
    rst3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("l3r_no_rv%0d", k), {31'd0, if3_rvalid}, 0);
    end

    if3_req = 1; if3_addr = 32'h10;
    n = 0;
    do begin @(negedge clk); n++; end while (!if3_gnt && n < 8);
    if3_req = 0;
    chk("l3c_gnt_lat", n, 1);
    chk("l3c_a", {25'd0, A3}, 4);
    n = 0;
    do begin @(negedge clk); n++; end while (!if3_rvalid && n < 12);
    chk("l3c_rv_lat", n, 4);
    chk("l3c_rdata", if3_rdata, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
